uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
// - Serial-to-parallel UART receiver that directly feeds the receive FIFO: drives Rx_Data/Data_Rdy into the FIFO's Rx_Data/Data_Rdy inputs.
// - Oversamples the asynchronous Rx_In line and locates mid-bit sample points. Delivers one DATA_BITS word per valid frame, LSB first.
// - Flags framing errors (and parity errors when built with parity).
// PARAMETERS
// - DATA_BITS   8   data bits per frame (5..9)
// - OVERSAMPLE  16  sample ticks per bit period (even, >=4)
// - BAUD_DIV    4   clk cycles per sample tick (>=1); one bit = BAUD_DIV*OVERSAMPLE clks
// - PARITY_ODD  0   0 = even parity, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
// - clk            in   1          system clock, all logic on posedge
// - rst            in   1          synchronous, active-high reset
// - Rx_In          in   1          asynchronous serial line, idle high
// - BIST_Mode      in   1          1 = suppress Data_Rdy and Rx_Data updates
// - Rx_Data        out  DATA_BITS  last valid received word
// - Data_Rdy       out  1          1-clk pulse: Rx_Data holds a new valid word
// - Framing_Error  out  1          1-clk pulse: stop bit sampled low
// - Parity_Error   out  1          1-clk pulse: parity mismatch
// - Busy           out  1          1 while the FSM is not IDLE
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high on rst. rst=1 at a posedge forces: FSM to IDLE; all counters to 0; synchronizer flops to 1.
// - Output reset values: Rx_Data=0, Data_Rdy=0, Framing_Error=0, Parity_Error=0, Busy=0.
// - Reset mid-frame aborts the frame. No Data_Rdy or error pulse is produced for the aborted frame.
// - Input synchronizer: Rx_In passes through a 2-FF synchronizer, giving rx_s. The falling-edge detector compares rx_s against a 1-clk delayed copy.
// - Tick generator:
//   - div_cnt width $clog2(BAUD_DIV)+1. It counts 0..BAUD_DIV-1, and tick=1 for one clk when it wraps.
//   - samp_cnt counts ticks 0..OVERSAMPLE-1.
//   - Both counters clear on the falling edge that starts a frame.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: a falling edge on rx_s -> START, Busy=1.
//   - START: at tick OVERSAMPLE/2-1 (mid start bit), rx_s=0 -> DATA with samp_cnt cleared. rx_s=1 -> IDLE; this is a glitch, and no flag is raised.
//   - DATA: each time samp_cnt reaches OVERSAMPLE-1, shift rx_s into shreg[DATA_BITS-1] (LSB first). bit_cnt (width $clog2(DATA_BITS+1)) increments.
//     After DATA_BITS samples -> PARITY if UART_RX_PARITY_EN is defined, else -> STOP.
//   - PARITY: sample one bit at the mid point and latch par_bad. Then -> STOP.
//   - STOP: sample at the mid point, then -> IDLE on the next clk.
//     - rx_s=1 and no parity error: Rx_Data<=shreg and Data_Rdy=1 on the next clk.
//     - rx_s=0: Framing_Error=1 for 1 clk. Rx_Data holds.
//     - par_bad: Parity_Error=1 for 1 clk. Rx_Data holds.
//     - Both errors can pulse in the same clk.
// - Framing error with the line held low (break): IDLE needs rx_s=1 before a new falling edge can arm START. So a break produces exactly one Framing_Error.
// - Latency: Data_Rdy asserts 1 clk after the stop-bit sample tick. The start edge on rx_s lags Rx_In by 2 clk.
// - Data_Rdy is always a single-clk pulse and is low between frames. This guarantees a rising edge for each word at the consumer.
// - BIST_Mode=1 at the stop-sample clk: Data_Rdy stays 0 and Rx_Data holds. Error pulses still occur. The FSM runs normally.
// - Back-to-back frames: a new start edge is accepted on the clk after STOP->IDLE. No extra idle bit is required.
// CONFIGURATION
// - Macro: UART_RX_PARITY_EN.
// - Defined: a frame is start + DATA_BITS + parity + stop. The PARITY state is present. Parity check:
//   - even (PARITY_ODD=0): XOR of data and parity bits must be 0.
//   - odd (PARITY_ODD=1): that XOR must be 1.
// - Undefined: a frame is start + DATA_BITS + stop. The PARITY state and its logic are removed. Parity_Error is tied to 0 and PARITY_ODD is ignored.
// TESTING
// - Defaults (bit = 64 clk). Send 0xA5: 0,1,0,1,0,0,1,0,1,1.
//   -> Rx_Data=0xA5. Data_Rdy high exactly 1 clk, about 9.5 bits after the start edge (plus 2 sync clk). No error flags.
// - Send 0x3C with the stop bit driven 0.
//   -> Framing_Error one 1-clk pulse, Data_Rdy=0, Rx_Data keeps its previous value.
//   - Then hold the line low for 3 bit times -> no further flags.
//   - Then release the line -> next frame 0x81 is received correctly.
// - Drive a 20-clk low glitch on the idle line -> Busy returns to 0 by clk ~34, with no Data_Rdy and no flags.
// - Send 0x11 and 0x22 back to back with zero idle bits -> two Data_Rdy pulses separated by 640 clk. Rx_Data is 0x11, then 0x22.
// - Assert rst mid-DATA of 0xFF, then send 0x5A.
//   -> Outputs are at reset values 1 clk after rst. No pulse for the aborted frame. 0x5A is received cleanly.
// - UART_RX_PARITY_EN with PARITY_ODD=0: send 0x07 with parity bit 1 -> Data_Rdy, Rx_Data=0x07.
//   Resend 0x07 with parity bit 0 -> Parity_Error pulse, no Data_Rdy. Also: BIST_Mode=1 during a valid frame -> no Data_Rdy.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// Receiver-side bundle: serial line and BIST control in, received word and status pulses out.
// The receiver is the master; the receive FIFO / consumer is the slave.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx_In;
  logic                 BIST_Mode;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Data_Rdy;
  logic                 Framing_Error;
  logic                 Parity_Error;
  logic                 Busy;

  modport master (
    input  Rx_In, BIST_Mode,
    output Rx_Data, Data_Rdy, Framing_Error, Parity_Error, Busy
  );

  modport slave (
    output Rx_In, BIST_Mode,
    input  Rx_Data, Data_Rdy, Framing_Error, Parity_Error, Busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start/data/[parity]/stop framing, mid-bit sampling, 1-clk status pulses.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_DIV   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_deserializer_if.master   bus
);
  localparam int DW = $clog2(BAUD_DIV) + 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic                 sync1, rx_s, rx_d;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 fall, tick, samp, mid_start, start_edge;

  assign fall       = rx_d & ~rx_s;
  assign tick       = (div_cnt == DIV_LAST);
  assign samp       = tick && (samp_cnt == SAMP_LAST);
  assign mid_start  = tick && (samp_cnt == SAMP_MID);
  assign start_edge = (state == IDLE) && fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= bus.Rx_In;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // Counters re-phase on the start edge so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst || start_edge) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (state == START && mid_start)
        samp_cnt <= '0;
      else if (tick)
        samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      shreg             <= '0;
      bus.Rx_Data       <= '0;
      bus.Data_Rdy      <= 1'b0;
      bus.Framing_Error <= 1'b0;
      bus.Busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad           <= 1'b0;
      bus.Parity_Error  <= 1'b0;
`endif
    end else begin
      bus.Data_Rdy      <= 1'b0;
      bus.Framing_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.Parity_Error  <= 1'b0;
`endif
      case (state)
        IDLE: if (fall) begin
          state    <= START;
          bus.Busy <= 1'b1;
        end
        START: if (mid_start) begin
          bit_cnt <= '0;
          if (!rx_s) state <= DATA;
          else begin
            state    <= IDLE;
            bus.Busy <= 1'b0;
          end
        end
        DATA: if (samp) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == BIT_LAST) state <= PARITY;
`else
          if (bit_cnt == BIT_LAST) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (samp) begin
          par_bad <= ((^shreg) ^ rx_s) != PAR_ODD;
          state   <= STOP;
        end
`endif
        STOP: if (samp) begin
          state             <= IDLE;
          bus.Busy          <= 1'b0;
          bus.Framing_Error <= ~rx_s;
`ifdef UART_RX_PARITY_EN
          bus.Parity_Error  <= par_bad;
`endif
          if (rx_s && !par_bad && !bus.BIST_Mode) begin
            bus.Rx_Data  <= shreg;
            bus.Data_Rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  logic unused_cfg;
  assign par_bad          = 1'b0;
  assign bus.Parity_Error = 1'b0;
  assign unused_cfg       = (PARITY_ODD != 0);
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at default parameters (bit = 64 clk).
// A negedge monitor counts status pulses; the main sequence checks the counts and captured words.
module tb_uart_rx_deserializer;
  localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Drive-to-Data_Rdy: 2 sync + 1 edge register + half start bit + data/parity bits + stop-bit sample
  localparam int LAT = 3 + BIT / 2 + (FRAME_BITS - 1) * BIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_deserializer_if #(.DATA_BITS(8)) bus ();

  uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY_ODD(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   rdy_rise = 0, rdy_hi = 0, fe_rise = 0, fe_hi = 0, pe_rise = 0;
  logic rdy_q = 1'b0, fe_q = 1'b0, pe_q = 1'b0;
  int   rdy_cyc [64];
  logic [7:0] rdy_word [64];

  always @(negedge clk) begin
    if (bus.Data_Rdy === 1'b1) begin
      rdy_hi++;
      if (!rdy_q) begin
        rdy_cyc[rdy_rise % 64]  = cyc;
        rdy_word[rdy_rise % 64] = bus.Rx_Data;
        rdy_rise++;
      end
    end
    if (bus.Framing_Error === 1'b1) begin
      fe_hi++;
      if (!fe_q) fe_rise++;
    end
    if (bus.Parity_Error === 1'b1 && !pe_q) pe_rise++;
    rdy_q = (bus.Data_Rdy === 1'b1);
    fe_q  = (bus.Framing_Error === 1'b1);
    pe_q  = (bus.Parity_Error === 1'b1);
  end

  int vectors = 0, miscompares = 0;
  int frame_start;
  int r0, h0, f0, fh0, p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.Rx_In = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`else
    if (bad_par) $display("note: parity flag ignored without parity build");
`endif
    drive_bit(stop);
  endtask

  task automatic snap();
    r0 = rdy_rise; h0 = rdy_hi; f0 = fe_rise; fh0 = fe_hi; p0 = pe_rise;
  endtask

  initial begin
    bus.Rx_In     = 1'b1;
    bus.BIST_Mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(bus.Rx_Data), 32'h0);
    chk("rst_data_rdy", 32'(bus.Data_Rdy), 32'h0);
    chk("rst_framing", 32'(bus.Framing_Error), 32'h0);
    chk("rst_parity", 32'(bus.Parity_Error), 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Clean 0xA5
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("a5_rdy_pulses", 32'(rdy_rise - r0), 32'd1);
    chk("a5_rdy_width", 32'(rdy_hi - h0), 32'd1);
    chk("a5_latency", 32'(rdy_cyc[r0 % 64] - frame_start), 32'(LAT));
    chk("a5_word", 32'(rdy_word[r0 % 64]), 32'hA5);
    chk("a5_rx_data", 32'(bus.Rx_Data), 32'hA5);
    chk("a5_no_fe", 32'(fe_rise - f0), 32'd0);
    chk("a5_no_pe", 32'(pe_rise - p0), 32'd0);
    chk("a5_idle_busy", 32'(bus.Busy), 32'h0);

    // 0x3C with stop low, then a 3-bit break, then recovery with 0x81
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    chk("break_fe_pulses", 32'(fe_rise - f0), 32'd1);
    chk("break_fe_width", 32'(fe_hi - fh0), 32'd1);
    chk("break_no_rdy", 32'(rdy_rise - r0), 32'd0);
    chk("break_rx_hold", 32'(bus.Rx_Data), 32'hA5);
    chk("break_busy", 32'(bus.Busy), 32'h0);
    drive_bit(1'b1);
    snap();
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("post_break_rdy", 32'(rdy_rise - r0), 32'd1);
    chk("post_break_word", 32'(bus.Rx_Data), 32'h81);
    chk("post_break_no_fe", 32'(fe_rise - f0), 32'd0);

    // 20-clk glitch on idle line
    snap();
    bus.Rx_In = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_set", 32'(bus.Busy), 32'h1);
    repeat (10) @(negedge clk);
    bus.Rx_In = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy_clr", 32'(bus.Busy), 32'h0);
    repeat (BIT * FRAME_BITS) @(negedge clk);
    chk("glitch_no_rdy", 32'(rdy_rise - r0), 32'd0);
    chk("glitch_no_fe", 32'(fe_rise - f0), 32'd0);
    chk("glitch_rx_hold", 32'(bus.Rx_Data), 32'h81);

    // Back-to-back 0x11, 0x22
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("b2b_pulses", 32'(rdy_rise - r0), 32'd2);
    chk("b2b_spacing", 32'(rdy_cyc[(r0 + 1) % 64] - rdy_cyc[r0 % 64]), 32'(FRAME_BITS * BIT));
    chk("b2b_word0", 32'(rdy_word[r0 % 64]), 32'h11);
    chk("b2b_word1", 32'(rdy_word[(r0 + 1) % 64]), 32'h22);

    // Reset in the middle of a 0xFF frame's data bits
    repeat (BIT) @(negedge clk);
    snap();
    drive_bit(1'b0);
    bus.Rx_In = 1'b1;
    repeat (200) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.Busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
    chk("mid_rst_rx_data", 32'(bus.Rx_Data), 32'h0);
    chk("mid_rst_rdy", 32'(bus.Data_Rdy), 32'h0);
    rst = 1'b0;
    repeat (BIT * FRAME_BITS) @(negedge clk);
    chk("abort_no_rdy", 32'(rdy_rise - r0), 32'd0);
    chk("abort_no_fe", 32'(fe_rise - f0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("after_rst_rdy", 32'(rdy_rise - r0), 32'd1);
    chk("after_rst_word", 32'(bus.Rx_Data), 32'h5A);

    // BIST mode suppresses delivery of a valid frame
    snap();
    bus.BIST_Mode = 1'b1;
    send_frame(8'h33, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    bus.BIST_Mode = 1'b0;
    chk("bist_no_rdy", 32'(rdy_rise - r0), 32'd0);
    chk("bist_rx_hold", 32'(bus.Rx_Data), 32'h5A);
    chk("bist_no_fe", 32'(fe_rise - f0), 32'd0);

    // Data boundary words
    snap();
    send_frame(8'h00, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("zero_word", 32'(bus.Rx_Data), 32'h00);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("ones_word", 32'(bus.Rx_Data), 32'hFF);
    chk("boundary_pulses", 32'(rdy_rise - r0), 32'd2);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("par_good_rdy", 32'(rdy_rise - r0), 32'd1);
    chk("par_good_word", 32'(bus.Rx_Data), 32'h07);
    chk("par_good_no_pe", 32'(pe_rise - p0), 32'd0);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("par_bad_pe", 32'(pe_rise - p0), 32'd1);
    chk("par_bad_no_rdy", 32'(rdy_rise - r0), 32'd0);
    chk("par_bad_no_fe", 32'(fe_rise - f0), 32'd0);
`else
    chk("no_parity_pe", 32'(pe_rise), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
